// File: rtl/multicycle_controller.sv
// Main control FSM and ALU/flag decoders for the multicycle ARM-subset datapath.
// Outputs are the unconditioned requests; the conditional-logic stage gates them.
module multicycle_controller #(
    parameter int STATE_W       = 4,
    parameter bit HOLD_ON_STALL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUControl,
    output logic [1:0]         FlagW,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic               NoWrite,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        EXECI    = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9)
    } state_t;

    state_t state_q, state_d;

    logic       rdy;
    logic       alu_op;
    logic       branch;
    logic       next_pc;
    logic [3:0] cmd;

    assign rdy   = HOLD_ON_STALL ? mem_ready : 1'b1;
    assign cmd   = Funct[4:1];
    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next state and Moore outputs
    always_comb begin
        state_d    = FETCH;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        RegW       = 1'b0;
        MemW       = 1'b0;
        alu_op     = 1'b0;
        branch     = 1'b0;
        next_pc    = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                next_pc   = rdy;
                state_d   = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc  = 1'b1;
                MemW    = rdy;
                state_d = rdy ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegW    = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // ALU decoder; NoWrite stays up through ALUWB so a CMP never writes back
    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        if (alu_op) begin
            case (cmd)
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
            FlagW[1] = Funct[0];
            FlagW[0] = Funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010));
        end
        if (alu_op || state_q == ALUWB)
            NoWrite = (cmd == 4'b1010);
    end

    assign PCS = branch | (RegW & (Rd == 4'b1111)) | next_pc;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; inputs change and outputs are sampled on negedge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       mem_ready;
    logic       IRWrite, AdrSrc, ALUSrcA, PCS, RegW, MemW, NoWrite, illegal_op;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_controller #(.STATE_W(4), .HOLD_ON_STALL(1'b1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .FlagW(FlagW), .PCS(PCS),
        .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
        Op = op; Funct = fn; Rd = rd;
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0;
        instr(2'b01, 6'b011001, 4'd2);
        tick();
        // reset state, stalled fetch
        chk("rst_state", state, 0);
        chk("rst_irw_stall", IRWrite, 0);
        chk("rst_pcs_stall", PCS, 0);
        chk("rst_srcb", ALUSrcB, 2'b10);
        chk("rst_srca", ALUSrcA, 1);
        chk("rst_ill", illegal_op, 0);
        mem_ready = 1'b1; #1;
        chk("rst_irw", IRWrite, 1);
        chk("rst_pcs", PCS, 1);
        reset = 1'b1;

        // LDR: 0,1,2,3,4,0
        tick(); chk("ldr_s1", state, 1); chk("ldr_dec_srcb", ALUSrcB, 2'b10); chk("ldr_dec_regw", RegW, 0);
        tick(); chk("ldr_s2", state, 2); chk("ldr_adr_srcb", ALUSrcB, 2'b01);
        tick(); chk("ldr_s3", state, 3); chk("ldr_rd_adrsrc", AdrSrc, 1); chk("ldr_rd_regw", RegW, 0);
        tick(); chk("ldr_s4", state, 4); chk("ldr_wb_regw", RegW, 1); chk("ldr_wb_res", ResultSrc, 2'b01);
        chk("ldr_wb_pcs", PCS, 0);
        tick(); chk("ldr_s0", state, 0); chk("ldr_end_regw", RegW, 0);

        // STR with 3 stalled cycles in MEMWRITE
        instr(2'b01, 6'b011000, 4'd3);
        tick(); chk("str_s1", state, 1);
        tick(); chk("str_s2", state, 2); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("str_hold_s", state, 5); chk("str_hold_memw", MemW, 0);
        end
        mem_ready = 1'b1; #1;
        chk("str_memw", MemW, 1); chk("str_adrsrc", AdrSrc, 1);
        tick(); chk("str_s0", state, 0); chk("str_end_memw", MemW, 0);

        // CMP
        instr(2'b00, 6'b010101, 4'd0);
        tick(); chk("cmp_s1", state, 1);
        tick(); chk("cmp_s6", state, 6); chk("cmp_aluc", ALUControl, 2'b01);
        chk("cmp_flagw", FlagW, 2'b11); chk("cmp_nowr", NoWrite, 1); chk("cmp_ex_regw", RegW, 0);
        tick(); chk("cmp_s8", state, 8); chk("cmp_wb_regw", RegW, 1); chk("cmp_wb_nowr", NoWrite, 1);
        chk("cmp_wb_flagw", FlagW, 0);
        tick(); chk("cmp_s0", state, 0);

        // ADD, Rd=PC, no S
        instr(2'b00, 6'b001000, 4'hF);
        tick(); tick(); chk("add_s6", state, 6); chk("add_aluc", ALUControl, 2'b00); chk("add_flagw", FlagW, 0);
        chk("add_nowr", NoWrite, 0);
        tick(); chk("add_s8", state, 8); chk("add_pcs", PCS, 1); chk("add_wb_nowr", NoWrite, 0);
        tick(); chk("add_s0", state, 0);

        // ORR immediate with S
        instr(2'b00, 6'b111001, 4'd1);
        tick(); tick(); chk("orr_s7", state, 7); chk("orr_aluc", ALUControl, 2'b11);
        chk("orr_flagw", FlagW, 2'b10); chk("orr_srcb", ALUSrcB, 2'b01);
        tick(); chk("orr_s8", state, 8); chk("orr_wb_pcs", PCS, 0);
        tick(); chk("orr_s0", state, 0);

        // AND register with S; SUB register with S
        instr(2'b00, 6'b000001, 4'd1);
        tick(); tick(); chk("and_aluc", ALUControl, 2'b10); chk("and_flagw", FlagW, 2'b10);
        tick(); tick(); chk("and_s0", state, 0);
        instr(2'b00, 6'b000101, 4'd1);
        tick(); tick(); chk("sub_aluc", ALUControl, 2'b01); chk("sub_flagw", FlagW, 2'b11);
        tick(); tick();

        // Branch
        instr(2'b10, 6'b000000, 4'd0);
        tick(); chk("b_s1", state, 1);
        tick(); chk("b_s9", state, 9); chk("b_pcs", PCS, 1); chk("b_srcb", ALUSrcB, 2'b01);
        chk("b_res", ResultSrc, 2'b10);
        tick(); chk("b_s0", state, 0);

        // Illegal Op
        instr(2'b11, 6'b000000, 4'd0);
        tick(); chk("ill_s1", state, 1); chk("ill_pulse", illegal_op, 1);
        tick(); chk("ill_s0", state, 0); chk("ill_clear", illegal_op, 0);

        // Fetch stall holds
        mem_ready = 1'b0; #1;
        chk("fst_irw", IRWrite, 0); chk("fst_pcs", PCS, 0);
        tick(); chk("fst_s0", state, 0);
        mem_ready = 1'b1;

        // Async reset during MEMREAD
        instr(2'b01, 6'b011001, 4'd2);
        tick(); tick(); chk("ar_s2", state, 2); mem_ready = 1'b0;
        tick(); chk("ar_s3", state, 3);
        #2 reset = 1'b0; #1;
        chk("ar_state", state, 0); chk("ar_regw", RegW, 0);
        tick(); chk("ar_hold_s", state, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("ar_post_regw", RegW, 0); chk("ar_post_s", state, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle ARM-subset datapath. A Moore FSM sequences fetch, decode, execute, memory and writeback steps. Combinational decoders produce the ALU and flag controls. Its unconditioned outputs (PCS, RegW, MemW, NoWrite, FlagW) feed the conditional-logic stage, which gates them with the condition result.

Parameters:
STATE_W, 4, width of the state register and of the debug state output.
HOLD_ON_STALL, 1, if 1, FETCH, MEMREAD and MEMWRITE wait for mem_ready; if 0, mem_ready is ignored (treated as 1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous reset, active-low (0 = reset asserted).
Op  in  2  instr[27:26].
Funct  in  6  instr[25:20]; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S/L.
Rd  in  4  instr[15:12].
mem_ready  in  1  memory ready for the current access.
IRWrite  out  1  instruction register load enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
ALUSrcA  out  1  ALU A select: 0 = register, 1 = PC.
ALUSrcB  out  2  ALU B select: 00 = register, 01 = extended immediate, 10 = constant 4.
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU direct.
ALUControl  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
FlagW  out  2  [1] = N,Z write; [0] = C,V write.
PCS  out  1  PC-write request (before condition check).
RegW  out  1  register-write request.
MemW  out  1  memory-write request.
NoWrite  out  1  suppress register write (CMP).
illegal_op  out  1  one-cycle pulse when Op=11 is decoded.
state  out  STATE_W  current state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH. All Moore outputs take the FETCH values immediately. illegal_op=0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH on the next edge.
- Moore outputs per state (unlisted outputs = 0, ALUSrcB and ResultSrc default 00):
  - FETCH: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=1 and NextPC (PCS source) asserted only in the cycle mem_ready=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1; MemW=1 only while mem_ready=1.
  - EXECR: ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- Transitions:
  - FETCH -> DECODE when mem_ready, else hold.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH with illegal_op=1 for that cycle.
  - MEMADR -> MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD -> MEMWB when mem_ready, else hold.
  - MEMWRITE -> FETCH when mem_ready, else hold.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, ALUWB and BRANCH -> FETCH.
- Cycle counts with zero stall: LDR 5, STR 4, data-processing 4, B 3, illegal 2.
- ALU decoder (combinational):
  - ALUOp=0 -> ALUControl=00, FlagW=00, NoWrite=0.
  - ALUOp=1: cmd 0100 -> 00; 0010 -> 01; 0000 -> 10; 1100 -> 11; 1010 (CMP) -> 01 with NoWrite=1; any other cmd -> 00.
  - FlagW[1]=Funct[0]. FlagW[0]=Funct[0] AND cmd is ADD, SUB or CMP.
  - FlagW is nonzero only in EXECR and EXECI.
- PCS = Branch OR (RegW AND Rd=1111) OR NextPC.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- Reset asserted mid-instruction aborts it. No RegW or MemW pulse is produced after reset falls.

Test Plan:
- Reset low, then high with mem_ready=1 -> state=0, IRWrite=1, PCS=1, ALUSrcB=10; next cycle state=1.
- LDR (Op=01, Funct=011001), mem_ready=1 -> states 0,1,2,3,4,0; RegW=1 only in MEMWB with ResultSrc=01.
- STR with mem_ready held low 3 cycles in MEMWRITE -> state holds at 5, MemW=0 while low; MemW=1 for exactly 1 cycle, then FETCH.
- CMP (Op=00, Funct=010101) -> EXECR shows ALUControl=01, FlagW=11, NoWrite=1; ALUWB shows RegW=1, NoWrite=1.
- ADD with Rd=1111 -> PCS=1 in ALUWB. ORR with S=1 -> FlagW=10.
- Op=11 in DECODE -> illegal_op=1 for 1 cycle, state returns to 0. Reset pulsed low during MEMREAD -> state=0 asynchronously, RegW never asserted.
